// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control blocks.
//   FWD_*      : ALU source-mux select encodings
//   mc_state_t : multi-cycle execute sequencer states
package core_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;  // register file value
  localparam logic [1:0] FWD_W   = 2'b01;  // writeback result
  localparam logic [1:0] FWD_M   = 2'b10;  // ALUoutM

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;
endpackage

// File: rtl/fwd_sel.sv
// Forward-select for one ALU operand.
//   src                 : source register read by the instruction in E
//   rdM/RegWriteM       : destination and write enable of the instruction in M
//   rdW/RegWriteW       : destination and write enable of the instruction in W
//   sel                 : FWD_M / FWD_W / FWD_REG
// M is younger than W, so its value wins. x0 is hardwired and never forwarded.
module fwd_sel
  import core_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] sel
);
  always_comb begin
    sel = FWD_REG;
    if (RegWriteM && (rdM != 5'd0) && (rdM == src))
      sel = FWD_M;
    else if (RegWriteW && (rdW != 5'd0) && (rdW == src))
      sel = FWD_W;
  end
endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller.
//   Inputs : register specifiers and write enables of D/E/M/W, load flag in E,
//            branch outcome in M, multi-cycle start in E.
//   Outputs: ALU forward selects, F/D/E stalls, D/E/M flushes, PC redirect,
//            multi-cycle busy/done, saturating stallF cycle counter.
// Priority: redirect > multi-cycle > load-use. All control outputs except
// mcBusy and stallCnt are combinational from the inputs and the FSM state.
module ex_hazard_ctrl
  import core_pkg::*;
#(
  parameter int MC_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCBranchM,
  input  logic             branchM,
  input  logic             mcStartE,
  output logic [1:0]       fwdAE,
  output logic [1:0]       fwdBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             redirectF,
  output logic             mcBusy,
  output logic             mcDone,
  output logic [CNT_W-1:0] stallCnt
);
  localparam int CW = $clog2(MC_LATENCY) + 1;

  mc_state_t     state;
  logic [CW-1:0] cnt;
  logic          taken, mcStart, mcStall, loadUse;

  fwd_sel uFwdA (.src(rs1E), .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM),
                 .RegWriteW(RegWriteW), .sel(fwdAE));
  fwd_sel uFwdB (.src(rs2E), .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM),
                 .RegWriteW(RegWriteW), .sel(fwdBE));

  assign taken   = PCBranchM & branchM;
  // A redirect squashes the op in E, so it must not start.
  assign mcStart = (state == IDLE) & mcStartE & ~taken;
  // Stall covers the start cycle plus every BUSY cycle before the done cycle.
  assign mcStall = mcStart | ((state == BUSY) & (cnt > CW'(1)));
  assign mcDone  = (state == BUSY) & (cnt == CW'(1));
  // Load-use yields to an active multi-cycle stall; it may coincide with mcDone.
  assign loadUse = MemtoRegE & RegWriteE & (rdE != 5'd0) &
                   ((rdE == rs1D) | (rdE == rs2D)) & ~mcStall & ~taken;

  assign redirectF = taken;
  assign stallF    = ~taken & (mcStall | loadUse);
  assign stallD    = ~taken & (mcStall | loadUse);
  assign stallE    = ~taken & mcStall;
  assign flushD    = taken;
  assign flushE    = taken | loadUse;
  assign flushM    = mcStall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mcBusy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mcStart) begin
          state  <= BUSY;
          cnt    <= CW'(MC_LATENCY - 1);
          mcBusy <= 1'b1;
        end
        BUSY: if (cnt > CW'(1)) begin
          cnt <= cnt - CW'(1);
        end else begin
          state  <= IDLE;
          cnt    <= '0;
          mcBusy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          mcBusy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stallCnt <= '0;
    else if (stallF && (stallCnt != {CNT_W{1'b1}}))
      stallCnt <= stallCnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;
  localparam int L     = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCBranchM, branchM, mcStartE;
  logic [1:0] fwdAE, fwdBE;
  logic stallF, stallD, stallE, flushD, flushE, flushM, redirectF, mcBusy, mcDone;
  logic [CNT_W-1:0] stallCnt;

  ex_hazard_ctrl #(.MC_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .PCBranchM(PCBranchM),
    .branchM(branchM), .mcStartE(mcStartE), .fwdAE(fwdAE), .fwdBE(fwdBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD),
    .flushE(flushE), .flushM(flushM), .redirectF(redirectF), .mcBusy(mcBusy),
    .mcDone(mcDone), .stallCnt(stallCnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCBranchM, branchM, mcStartE;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sF, sD, sE, fD, fE, fM, rF, busy, done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   nTests = 0, nFail = 0;
  // Reference state: position of the op in its L-cycle occupancy of E (0 = none),
  // and total number of cycles the front end has been stalled since reset.
  int   opCycle = 0;
  int   stallTotal = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Nearest older producer that writes a non-zero register matching src.
  function automatic logic [1:0] refFwd(input logic [4:0] src, input stim_t s);
    if (src == 5'd0) return 2'b00;
    if (s.RegWriteM && s.rdM == src) return 2'b10;
    if (s.RegWriteW && s.rdW == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    int   k;
    logic taken, hold, lu;
    @(posedge clk); #1;
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = {s.rs1D, s.rs2D, s.rs1E, s.rs2E, s.rdE, s.rdM, s.rdW};
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = {s.RegWriteE, s.RegWriteM, s.RegWriteW, s.MemtoRegE};
    {PCBranchM, branchM, mcStartE} = {s.PCBranchM, s.branchM, s.mcStartE};
    taken = s.PCBranchM & s.branchM;
    k = opCycle;
    if (k == 0 && s.mcStartE && !taken) k = 1;
    hold = (k >= 1) && (k < L);
    lu = s.MemtoRegE && s.RegWriteE && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D) && !hold;
    e.fa   = refFwd(s.rs1E, s);
    e.fb   = refFwd(s.rs2E, s);
    e.sF   = !taken && (hold || lu);
    e.sD   = e.sF;
    e.sE   = !taken && hold;
    e.fD   = taken;
    e.fE   = taken || lu;
    e.fM   = hold;
    e.rF   = taken;
    e.done = (k == L);
    e.busy = (k >= 2);
    e.cnt  = CNT_W'((stallTotal > SAT) ? SAT : stallTotal);
    q.push_back(e);
    if (e.sF) stallTotal++;
    opCycle = (k == 0 || k == L) ? 0 : k + 1;
  endtask

  task automatic doReset();
    @(negedge clk); #2;
    rst = 1'b0; #1;
    chk("rst_mcBusy", mcBusy, 0);
    chk("rst_stallCnt", stallCnt, 0);
    chk("rst_mcDone", mcDone, 0);
    opCycle = 0; stallTotal = 0;
    @(negedge clk); #2;
    rst = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents a full set of control outputs.
  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        m = q.pop_front();
        chk("fwdAE", fwdAE, m.fa);       chk("fwdBE", fwdBE, m.fb);
        chk("stallF", stallF, m.sF);     chk("stallD", stallD, m.sD);
        chk("stallE", stallE, m.sE);     chk("flushD", flushD, m.fD);
        chk("flushE", flushE, m.fE);     chk("flushM", flushM, m.fM);
        chk("redirectF", redirectF, m.rF);
        chk("mcBusy", mcBusy, m.busy);   chk("mcDone", mcDone, m.done);
        chk("stallCnt", stallCnt, m.cnt);
      end
    end
  end

  stim_t z;
  initial begin
    z = '0;
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCBranchM, branchM, mcStartE} = '0;
    #2;
    chk("init_mcBusy", mcBusy, 0);
    chk("init_stallCnt", stallCnt, 0);
    chk("init_mcDone", mcDone, 0);
    chk("init_fwdAE", fwdAE, 0);
    #10 rst = 1'b1;

    begin : directed
      stim_t s;
      // Forwarding: M beats W; x0 never forwarded.
      s = z; s.rdM = 5; s.RegWriteM = 1; s.rdW = 5; s.RegWriteW = 1; s.rs1E = 5; apply(s);
      s.rdM = 0; s.rs1E = 0; apply(s);
      s = z; s.rdW = 9; s.RegWriteW = 1; s.rs2E = 9; s.rs1E = 9; s.rdM = 9; apply(s);
      // Load-use: one bubble, count becomes 1.
      s = z; s.MemtoRegE = 1; s.RegWriteE = 1; s.rdE = 7; s.rs2D = 7; apply(s);
      apply(z); apply(z);
      // Multi-cycle op with mcStartE held for the op, then one idle cycle.
      doReset();
      s = z; s.mcStartE = 1;
      for (int i = 0; i < L; i++) apply(s);
      apply(z);
      // Redirect together with mcStartE: no op starts.
      s = z; s.PCBranchM = 1; s.branchM = 1; s.mcStartE = 1; apply(s);
      apply(z); apply(z);
      // mcDone coinciding with a load-use in D.
      s = z; s.mcStartE = 1; apply(s);
      for (int i = 0; i < L - 2; i++) apply(z);
      s = z; s.MemtoRegE = 1; s.RegWriteE = 1; s.rdE = 3; s.rs1D = 3; apply(s);
      apply(z);
      // Reset during BUSY cycle 2 aborts the op; no mcDone afterwards.
      doReset();
      s = z; s.mcStartE = 1; apply(s);
      apply(z);
      doReset();
      for (int i = 0; i < L + 1; i++) apply(z);
      // Saturation of stallCnt.
      s = z; s.MemtoRegE = 1; s.RegWriteE = 1; s.rdE = 4; s.rs1D = 4;
      for (int i = 0; i < (1 << CNT_W) + 5; i++) apply(s);
      apply(z);
    end

    begin : random_phase
      stim_t s;
      doReset();
      for (int i = 0; i < 400; i++) begin
        s.rs1D = 5'($urandom_range(0, 7)); s.rs2D = 5'($urandom_range(0, 7));
        s.rs1E = 5'($urandom_range(0, 7)); s.rs2E = 5'($urandom_range(0, 7));
        s.rdE  = 5'($urandom_range(0, 7)); s.rdM  = 5'($urandom_range(0, 7));
        s.rdW  = 5'($urandom_range(0, 7));
        s.RegWriteE = 1'($urandom); s.RegWriteM = 1'($urandom); s.RegWriteW = 1'($urandom);
        s.MemtoRegE = 1'($urandom);
        s.mcStartE  = ($urandom_range(0, 5) == 0);
        s.branchM   = 1'($urandom);
        // M holds bubbles while an op occupies E, so no branch can be there.
        s.PCBranchM = (opCycle == 0) && ($urandom_range(0, 5) == 0);
        apply(s);
      end
      apply(z);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
